// File: rtl/gmii_rx_frame_ctrl_if.sv
// GMII receive bundle as delivered by the DDR-to-SDR converter.
// error carries DV xor ER from the RGMII falling-edge sample.
interface gmii_if;
    logic [7:0] data;
    logic       valid;
    logic       error;

    modport master (output data, output valid, output error);
    modport slave  (input data, input valid, input error);
endinterface

// File: rtl/gmii_rx_frame_ctrl.sv
// GMII receive framer: preamble/SFD tracking, length policing,
// SOP/EOP/error marking and frame statistics.
module gmii_rx_frame_ctrl #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    gmii_if.slave            gmii_if_rx_i,
    input  logic             en_i,
    output logic [7:0]       m_data_o,
    output logic             m_valid_o,
    output logic             m_sop_o,
    output logic             m_eop_o,
    output logic             m_err_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic [CNT_W-1:0] bad_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o
);
    localparam int LEN_RAW = $clog2(MAX_LEN + 2);
    localparam int LEN_W   = (LEN_RAW < 11) ? 11 : LEN_RAW;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic       dv;
    logic       rx_er;
    logic [7:0] rxd;

    assign dv    = gmii_if_rx_i.valid;
    assign rx_er = gmii_if_rx_i.valid ^ gmii_if_rx_i.error;
    assign rxd   = gmii_if_rx_i.data;

    logic [1:0]       state_q, state_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ferr_q, ferr_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic             merr_q, merr_d;
    logic             zl_q, zl_d;
    logic             drop_inc;
    logic             pre_byte;

    logic [CNT_W-1:0] frame_cnt_q, bad_cnt_q, drop_cnt_q;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        len_d      = len_q;
        ferr_d     = ferr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        sop_d      = 1'b0;
        eop_d      = 1'b0;
        merr_d     = 1'b0;
        zl_d       = 1'b0;
        drop_inc   = 1'b0;
        pre_byte   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (dv && !en_i) begin
                    state_d  = S_DROP;
                    drop_inc = 1'b1;
                end else if (dv) begin
                    pre_byte = 1'b1;
                end
            end
            S_PRE: begin
                if (!dv) begin
                    state_d  = S_IDLE;
                    drop_inc = 1'b1;
                end else begin
                    pre_byte = 1'b1;
                end
            end
            S_DATA: begin
                // Held byte leaves once this cycle's dv decides EOP.
                if (hold_vld_q) begin
                    valid_d = 1'b1;
                    data_d  = hold_q;
                    sop_d   = (len_q == LEN_ONE);
                    if (!dv) begin
                        eop_d  = 1'b1;
                        merr_d = ferr_q | (len_q < LEN_MIN);
                    end else if (len_q >= LEN_MAX) begin
                        eop_d  = 1'b1;
                        merr_d = 1'b1;
                    end
                end
                if (!dv) begin
                    state_d    = S_IDLE;
                    hold_vld_d = 1'b0;
                    zl_d       = ~hold_vld_q;
                end else if (hold_vld_q && len_q >= LEN_MAX) begin
                    state_d    = S_DROP;
                    hold_vld_d = 1'b0;
                    len_d      = LEN_SAT;
                end else begin
                    hold_d     = rxd;
                    hold_vld_d = 1'b1;
                    len_d      = (len_q >= LEN_SAT) ? len_q : len_q + LEN_ONE;
                    ferr_d     = ferr_q | rx_er;
                end
            end
            S_DROP: begin
                if (!dv) state_d = S_IDLE;
            end
        endcase

        // IDLE hands the first byte straight to the preamble check so a
        // bare SFD is accepted.
        if (pre_byte) begin
            if (rx_er || (rxd != 8'h55 && rxd != 8'hD5)) begin
                state_d  = S_DROP;
                drop_inc = 1'b1;
            end else if (rxd == 8'hD5) begin
                state_d    = S_DATA;
                len_d      = '0;
                ferr_d     = 1'b0;
                hold_vld_d = 1'b0;
            end else begin
                state_d = S_PRE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            len_q      <= '0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            merr_q     <= 1'b0;
            zl_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            len_q      <= len_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            merr_q     <= merr_d;
            zl_q       <= zl_d;
        end
    end

    // A zero-length frame is a runt with no bytes to mark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            bad_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (eop_q && !merr_q)
                frame_cnt_q <= frame_cnt_q + 1'b1;
            if ((eop_q && merr_q) || zl_q)
                bad_cnt_q <= bad_cnt_q + 1'b1;
            if (drop_inc)
                drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign m_data_o    = data_q;
    assign m_valid_o   = valid_q;
    assign m_sop_o     = sop_q;
    assign m_eop_o     = eop_q;
    assign m_err_o     = merr_q;
    assign frame_cnt_o = frame_cnt_q;
    assign bad_cnt_o   = bad_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;
endmodule

// File: tb/tb_gmii_rx_frame_ctrl.sv
// Bench for gmii_rx_frame_ctrl: frame table plus scoreboard of
// expected output bytes, with reset corner sequences.
module tb_gmii_rx_frame_ctrl;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en_i;
    logic [7:0]       m_data_o;
    logic             m_valid_o, m_sop_o, m_eop_o, m_err_o;
    logic [CNT_W-1:0] frame_cnt_o, bad_cnt_o, drop_cnt_o;

    gmii_if rx();

    gmii_rx_frame_ctrl #(
        .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .gmii_if_rx_i(rx),
        .en_i        (en_i),
        .m_data_o    (m_data_o),
        .m_valid_o   (m_valid_o),
        .m_sop_o     (m_sop_o),
        .m_eop_o     (m_eop_o),
        .m_err_o     (m_err_o),
        .frame_cnt_o (frame_cnt_o),
        .bad_cnt_o   (bad_cnt_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         sop;
        bit         eop;
        bit         err;
        int         cyc;
    } sb_t;

    sb_t exp_q[$];
    sb_t e;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && m_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_valid: got byte %0h, required none", m_data_o);
            end else begin
                e = exp_q.pop_front();
                chk("data", m_data_o, e.data);
                chk("sop", m_sop_o, e.sop);
                chk("eop", m_eop_o, e.eop);
                chk("latency_cycle", cyc, e.cyc);
                if (e.eop) chk("eop_err", m_err_o, e.err);
            end
        end
    end

    task automatic drive(input logic [7:0] d, input bit dv, input bit er);
        @(negedge clk);
        rx.data  = d;
        rx.valid = dv;
        rx.error = dv ^ er;
    endtask

    typedef enum int { K_GOOD, K_BAD, K_DROP } kind_e;

    typedef struct {
        int    npre;
        int    plen;
        int    er_idx;
        bit    en;
        bit    en_mid;
        int    bad_pre;
        int    gap;
        kind_e kind;
    } vec_t;

    task automatic send(input vec_t v);
        sb_t s;
        if (!v.en) en_i = 1'b0;
        for (int i = 0; i < v.npre; i++) drive(8'h55, 1'b1, 1'b0);
        if (v.bad_pre >= 0) begin
            drive(8'(v.bad_pre), 1'b1, 1'b0);
            for (int i = 0; i < 5; i++) drive(8'(8'hA0 + i), 1'b1, 1'b0);
        end else begin
            drive(8'hD5, 1'b1, 1'b0);
            if (v.en_mid) en_i = 1'b0;
            for (int i = 0; i < v.plen; i++) begin
                drive(8'(i), 1'b1, i == v.er_idx);
                if (v.en && i < MAX_LEN) begin
                    s.data = 8'(i);
                    s.sop  = (i == 0);
                    s.eop  = (i == v.plen - 1) || (i == MAX_LEN - 1);
                    s.err  = (v.er_idx >= 0 && v.er_idx <= i) ||
                             (v.plen < MIN_LEN) || (v.plen > MAX_LEN);
                    s.cyc  = cyc + 2;
                    exp_q.push_back(s);
                end
            end
        end
        en_i = 1'b1;
    endtask

    vec_t vecs[17];
    int   m_frame = 0;
    int   m_bad   = 0;
    int   m_drop  = 0;

    initial begin
        vecs[0]  = '{7, 64,   -1, 1'b1, 1'b0, -1,    4, K_GOOD};
        vecs[1]  = '{7, 64,   10, 1'b1, 1'b0, -1,    4, K_BAD};
        vecs[2]  = '{7, 40,   -1, 1'b1, 1'b0, -1,    4, K_BAD};
        vecs[3]  = '{7, 1600, -1, 1'b1, 1'b0, -1,    4, K_BAD};
        vecs[4]  = '{7, 64,   -1, 1'b0, 1'b0, -1,    4, K_DROP};
        vecs[5]  = '{2, 0,    -1, 1'b1, 1'b0, 'h12,  4, K_DROP};
        vecs[6]  = '{7, 64,   -1, 1'b1, 1'b0, -1,    4, K_GOOD};
        vecs[7]  = '{7, 64,   -1, 1'b1, 1'b0, -1,    1, K_GOOD};
        vecs[8]  = '{7, 64,   -1, 1'b1, 1'b0, -1,    4, K_GOOD};
        vecs[9]  = '{0, 64,   -1, 1'b1, 1'b0, -1,    4, K_GOOD};
        vecs[10] = '{7, 1,    -1, 1'b1, 1'b0, -1,    4, K_BAD};
        vecs[11] = '{7, 0,    -1, 1'b1, 1'b0, -1,    4, K_BAD};
        vecs[12] = '{7, 64,   63, 1'b1, 1'b0, -1,    4, K_BAD};
        vecs[13] = '{7, 1518, -1, 1'b1, 1'b0, -1,    4, K_GOOD};
        vecs[14] = '{7, 1519, -1, 1'b1, 1'b0, -1,    4, K_BAD};
        vecs[15] = '{7, 64,   -1, 1'b1, 1'b1, -1,    4, K_GOOD};
        vecs[16] = '{7, 63,   -1, 1'b1, 1'b0, -1,    4, K_BAD};

        rst_n    = 1'b0;
        en_i     = 1'b1;
        rx.data  = 8'h00;
        rx.valid = 1'b0;
        rx.error = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", m_data_o, 0);
        chk("rst_valid", m_valid_o, 0);
        chk("rst_sop", m_sop_o, 0);
        chk("rst_eop", m_eop_o, 0);
        chk("rst_err", m_err_o, 0);
        chk("rst_frame_cnt", frame_cnt_o, 0);
        chk("rst_bad_cnt", bad_cnt_o, 0);
        chk("rst_drop_cnt", drop_cnt_o, 0);
        rst_n = 1'b1;

        // Carrier extension while idle must be ignored.
        for (int i = 0; i < 3; i++) drive(8'h0F, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(8'h00, 1'b0, 1'b0);
        chk("cext_drop_cnt", drop_cnt_o, 0);
        chk("cext_bad_cnt", bad_cnt_o, 0);

        for (int k = 0; k < 17; k++) begin
            send(vecs[k]);
            for (int g = 0; g < vecs[k].gap; g++) drive(8'h00, 1'b0, 1'b0);
            case (vecs[k].kind)
                K_GOOD:  m_frame++;
                K_BAD:   m_bad++;
                default: m_drop++;
            endcase
            if (vecs[k].gap > 2) begin
                chk($sformatf("v%0d_frame_cnt", k), frame_cnt_o, m_frame);
                chk($sformatf("v%0d_bad_cnt", k), bad_cnt_o, m_bad);
                chk($sformatf("v%0d_drop_cnt", k), drop_cnt_o, m_drop);
                chk($sformatf("v%0d_pending", k), exp_q.size(), 0);
            end
        end

        // Reset in the middle of a frame.
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            drive(8'(i), 1'b1, 1'b0);
            e.data = 8'(i);
            e.sop  = (i == 0);
            e.eop  = 1'b0;
            e.err  = 1'b0;
            e.cyc  = cyc + 2;
            exp_q.push_back(e);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", m_valid_o, 0);
        chk("mid_rst_eop", m_eop_o, 0);
        chk("mid_rst_data", m_data_o, 0);
        chk("mid_rst_frame_cnt", frame_cnt_o, 0);
        chk("mid_rst_bad_cnt", bad_cnt_o, 0);
        chk("mid_rst_drop_cnt", drop_cnt_o, 0);
        exp_q.delete();
        drive(8'd40, 1'b1, 1'b0);
        rst_n = 1'b1;
        for (int i = 41; i < 64; i++) drive(8'(i), 1'b1, 1'b0);
        for (int g = 0; g < 4; g++) drive(8'h00, 1'b0, 1'b0);
        chk("post_rst_frame_cnt", frame_cnt_o, 0);
        chk("post_rst_bad_cnt", bad_cnt_o, 0);
        chk("post_rst_drop_cnt", drop_cnt_o, 1);
        chk("post_rst_pending", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
